// File: rtl/dmem_arbiter_pkg.sv
// Shared types and byte-lane helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  // Pull one byte out of a word; lane 0 is bits [7:0].
  function automatic logic [7:0] extract_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [7:0] result;
    case (lane)
      2'd0:    result = word[7:0];
      2'd1:    result = word[15:8];
      2'd2:    result = word[23:16];
      default: result = word[31:24];
    endcase
    return result;
  endfunction

  // Replace one byte lane of a word, keeping the other three lanes.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    case (lane)
      2'd0:    result[7:0]   = data;
      2'd1:    result[15:8]  = data;
      2'd2:    result[23:16] = data;
      default: result[31:24] = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, external-port and dmem signals around the arbiter.
// slave = arbiter side, master = environment (CPU, loader, memory) side.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic          cpu_b;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;

  logic          ext_valid;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [31:0]   ext_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_b, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_b, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter_byte_lane.sv
// Combinational byte extract (for LDRB) and byte merge (for STRB).
module byte_lane
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_word,
  input  logic [1:0]  lane,
  input  logic [7:0]  wr_byte,
  output logic [31:0] rd_byte_zx,
  output logic [31:0] wr_merged
);

  assign rd_byte_zx = {24'h0, extract_byte(rd_word, lane)};
  assign wr_merged  = merge_byte(wr_word, lane, wr_byte);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU and an external
// loader/debug port. Byte stores use a two-cycle read-modify-write.
// Optional ARB_FAIRNESS_EN adds a starvation counter that forces an
// ext grant after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic [31:0]   rmw_word_q, rmw_word_d;
  logic          ext_rvalid_q, ext_rvalid_d;
  logic [31:0]   ext_rdata_q, ext_rdata_d;

  logic          ext_grant;
  logic          force_ext;
  logic          cpu_stall;
  logic [31:0]   cpu_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [31:0]   lane_rd;
  logic [31:0]   lane_merged;

  byte_lane u_byte_lane (
    .rd_word   (bus.mem_rd),
    .wr_word   (rmw_word_q),
    .lane      (bus.cpu_addr[1:0]),
    .wr_byte   (bus.cpu_wdata[7:0]),
    .rd_byte_zx(lane_rd),
    .wr_merged (lane_merged)
  );

`ifdef ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  // Count consecutive denied ext cycles, saturating at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ext_grant || !bus.ext_valid) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign force_ext = (state_q == IDLE) && bus.ext_valid &&
                     (starve_cnt_q == CW'(STARVE_LIMIT));
`else
  assign force_ext = 1'b0;
`endif

  // Arbitration, next state and all port outputs; everything quiet in reset
  always_comb begin
    state_d      = state_q;
    rmw_word_d   = rmw_word_q;
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    ext_grant    = 1'b0;
    cpu_stall    = 1'b0;
    cpu_rdata    = '0;
    mem_we       = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (force_ext) begin
            ext_grant = 1'b1;
            cpu_stall = 1'b1;
          end else if (bus.cpu_req) begin
            mem_a = bus.cpu_addr;
            if (bus.cpu_we && bus.cpu_b) begin
              cpu_stall  = 1'b1;
              rmw_word_d = bus.mem_rd;
              state_d    = RMW;
            end else if (bus.cpu_we) begin
              mem_we = 1'b1;
              mem_wd = bus.cpu_wdata;
            end else if (bus.cpu_b) begin
              cpu_rdata = lane_rd;
            end else begin
              cpu_rdata = bus.mem_rd;
            end
          end else if (bus.ext_valid) begin
            ext_grant = 1'b1;
          end
        end
        RMW: begin
          mem_a   = bus.cpu_addr;
          mem_we  = 1'b1;
          mem_wd  = lane_merged;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (ext_grant) begin
        mem_a  = bus.ext_addr & ~AW'(3);
        mem_we = bus.ext_we;
        mem_wd = bus.ext_wdata;
        if (!bus.ext_we) begin
          ext_rvalid_d = 1'b1;
          ext_rdata_d  = bus.mem_rd;
        end
      end
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rmw_word_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rmw_word_q   <= rmw_word_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.ext_ready  = ext_grant;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.mem_we     = mem_we;
  assign bus.mem_a      = mem_a;
  assign bus.mem_wd     = mem_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] mem [0:63];

  dmem_arbiter_if #(.AW(32)) bus ();

  dmem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, clocked-write memory behind the arbiter
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, settle before sampling
  task automatic apply_stimulus(input logic req, input logic we, input logic b,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ev, input logic ewe,
                                input logic [31:0] eaddr, input logic [31:0] ewdata);
    @(negedge clk);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_b     = b;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.ext_valid = ev;
    bus.ext_we    = ewe;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewdata;
    #2;
  endtask

  logic [31:0] lane_exp [0:3];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    lane_exp[0] = 32'h44;
    lane_exp[1] = 32'h33;
    lane_exp[2] = 32'h22;
    lane_exp[3] = 32'h11;

    // Reset with both requesters active: all outputs must stay quiet
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    check_output("rst_cpu_stall", bus.cpu_stall, 0);
    check_output("rst_ext_ready", bus.ext_ready, 0);
    check_output("rst_ext_rvalid", bus.ext_rvalid, 0);
    check_output("rst_ext_rdata", bus.ext_rdata, 0);
    check_output("rst_mem_we", bus.mem_we, 0);
    check_output("rst_cpu_rdata", bus.cpu_rdata, 0);
    reset = 1'b1;

    // Load memory through the ext port (low address bits ignored)
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h13, 32'h11223344);
    check_output("extw_ready", bus.ext_ready, 1);
    check_output("extw_mem_we", bus.mem_we, 1);
    check_output("extw_mem_a", bus.mem_a, 32'h10);
    check_output("extw_mem_wd", bus.mem_wd, 32'h11223344);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF);
    check_output("extw2_ready", bus.ext_ready, 1);

    // Idle: port parked
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("idle_mem_a", bus.mem_a, 0);
    check_output("idle_mem_we", bus.mem_we, 0);
    check_output("idle_ext_rvalid", bus.ext_rvalid, 0);

    // Byte loads across all four lanes
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0, 1, 32'h10 + i, 32'h0, 0, 0, 32'h0, 32'h0);
      check_output($sformatf("ldrb_lane%0d", i), bus.cpu_rdata, lane_exp[i]);
      check_output($sformatf("ldrb_stall%0d", i), bus.cpu_stall, 0);
    end

    // Word load
    apply_stimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("ldr_rdata", bus.cpu_rdata, 32'h11223344);
    check_output("ldr_mem_we", bus.mem_we, 0);

    // Byte store: read cycle stalls, write cycle merges; ext blocked in RMW
    apply_stimulus(1, 1, 1, 32'h11, 32'hFFFFFFAA, 0, 0, 32'h0, 32'h0);
    check_output("strb1_stall", bus.cpu_stall, 1);
    check_output("strb1_mem_we", bus.mem_we, 0);
    apply_stimulus(1, 1, 1, 32'h11, 32'hFFFFFFAA, 1, 0, 32'h20, 32'h0);
    check_output("strb2_stall", bus.cpu_stall, 0);
    check_output("strb2_mem_we", bus.mem_we, 1);
    check_output("strb2_mem_wd", bus.mem_wd, 32'h1122AA44);
    check_output("strb2_mem_a", bus.mem_a, 32'h11);
    check_output("strb2_ext_ready", bus.ext_ready, 0);
    apply_stimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("strb_readback", bus.cpu_rdata, 32'h1122AA44);

    // External read with registered return data
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    check_output("extr_ready", bus.ext_ready, 1);
    check_output("extr_mem_we", bus.mem_we, 0);
    check_output("extr_mem_a", bus.mem_a, 32'h20);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("extr_rvalid", bus.ext_rvalid, 1);
    check_output("extr_rdata", bus.ext_rdata, 32'hDEADBEEF);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("extr_rvalid_drop", bus.ext_rvalid, 0);
    check_output("extr_rdata_hold", bus.ext_rdata, 32'hDEADBEEF);

    // Word store wins over a simultaneous ext request
    apply_stimulus(1, 1, 0, 32'h24, 32'h0BADF00D, 1, 0, 32'h20, 32'h0);
    check_output("str_mem_we", bus.mem_we, 1);
    check_output("str_mem_wd", bus.mem_wd, 32'h0BADF00D);
    check_output("str_stall", bus.cpu_stall, 0);
    check_output("str_ext_ready", bus.ext_ready, 0);
    apply_stimulus(1, 0, 0, 32'h24, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("str_readback", bus.cpu_rdata, 32'h0BADF00D);

    // Contention held high: ext starves unless fairness is built in
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
      check_output($sformatf("starve%0d_ready", i), bus.ext_ready, 0);
      check_output($sformatf("starve%0d_stall", i), bus.cpu_stall, 0);
    end
    apply_stimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
`ifdef ARB_FAIRNESS_EN
    check_output("starve5_ready", bus.ext_ready, 1);
    check_output("starve5_stall", bus.cpu_stall, 1);
    check_output("starve5_mem_a", bus.mem_a, 32'h20);
`else
    check_output("starve5_ready", bus.ext_ready, 0);
    check_output("starve5_stall", bus.cpu_stall, 0);
    check_output("starve5_mem_a", bus.mem_a, 32'h10);
`endif
    apply_stimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
    check_output("starve6_ready", bus.ext_ready, 0);
`ifdef ARB_FAIRNESS_EN
    check_output("starve6_rvalid", bus.ext_rvalid, 1);
`else
    check_output("starve6_rvalid", bus.ext_rvalid, 0);
`endif

    // Reset in the middle of a byte store abandons the write
    apply_stimulus(1, 1, 1, 32'h22, 32'h00000055, 0, 0, 32'h0, 32'h0);
    check_output("rmwrst_stall", bus.cpu_stall, 1);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_output("rmwrst_mem_we", bus.mem_we, 0);
    check_output("rmwrst_cpu_stall", bus.cpu_stall, 0);
    @(negedge clk);
    check_output("rmwrst_hold_mem_we", bus.mem_we, 0);
    bus.cpu_req   = 1'b0;
    bus.ext_valid = 1'b0;
    reset         = 1'b1;
    #2;
    check_output("post_rst_mem_we", bus.mem_we, 0);
    check_output("post_rst_stall", bus.cpu_stall, 0);
    check_output("post_rst_ext_rvalid", bus.ext_rvalid, 0);
    check_output("post_rst_ext_rdata", bus.ext_rdata, 0);
    check_output("post_rst_cpu_rdata", bus.cpu_rdata, 0);
    check_output("post_rst_ext_ready", bus.ext_ready, 0);
    apply_stimulus(1, 0, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    check_output("post_rst_word_intact", bus.cpu_rdata, 32'hDEADBEEF);
    check_output("post_rst_idle_stall", bus.cpu_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
